// File: rtl/vrased_reset_ctrl.sv
// ============================================================================
// vrased_reset_ctrl: turns VRASED monitor violations into a timed core reset.
// Optional macro VRASED_CAUSE_LOG_EN keeps the cause/viol_cnt logging regs.
// Rev 1.0
// ============================================================================
`default_nettype none

module vrased_reset_ctrl #(
  parameter logic [15:0] HOLD_CYCLES   = 16'h0010,
  parameter logic [15:0] RESET_HANDLER = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  viol,
  input  logic [15:0] pc,
  output logic        sys_rst,
  output logic        busy,
  output logic [5:0]  cause,
  output logic [7:0]  viol_cnt
);

  // A zero hold length still produces one reset cycle.
  localparam logic [15:0] HOLD_LOAD = (HOLD_CYCLES == 16'd0) ? 16'd0 : HOLD_CYCLES - 16'd1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    WAIT_PC = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] hold_ctr_q, hold_ctr_d;
  logic        sys_rst_q, busy_q;

  always_comb begin
    state_d    = state_q;
    hold_ctr_d = hold_ctr_q;
    case (state_q)
      IDLE: begin
        if (|viol) begin
          state_d    = HOLD;
          hold_ctr_d = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (hold_ctr_q == 16'd0) state_d = WAIT_PC;
        else                     hold_ctr_d = hold_ctr_q - 16'd1;
      end
      WAIT_PC: begin
        if (|viol) begin
          state_d    = HOLD;
          hold_ctr_d = HOLD_LOAD;
        end else if (pc == RESET_HANDLER) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs get their own flops so nothing decodes combinationally to a port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      hold_ctr_q <= 16'd0;
      sys_rst_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_ctr_q <= hold_ctr_d;
      sys_rst_q  <= (state_d == HOLD);
      busy_q     <= (state_d != IDLE);
    end
  end

  assign sys_rst = sys_rst_q;
  assign busy    = busy_q;

`ifdef VRASED_CAUSE_LOG_EN
  logic [5:0] cause_q, cause_d;
  logic [7:0] cnt_q, cnt_d;
  logic       start_ep;

  assign start_ep = (|viol) && ((state_q == IDLE) || (state_q == WAIT_PC));

  always_comb begin
    cause_d = cause_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) begin
      if (|viol) cause_d = viol;
    end else begin
      cause_d = cause_q | viol;
    end
    if (start_ep && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cause_q <= 6'd0;
      cnt_q   <= 8'd0;
    end else begin
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cause    = cause_q;
  assign viol_cnt = cnt_q;
`else
  assign cause    = 6'd0;
  assign viol_cnt = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vrased_reset_ctrl.sv
// Scoreboard bench for vrased_reset_ctrl: default-hold instance A, zero-hold instance B.
`default_nettype none

module tb_vrased_reset_ctrl;

`ifdef VRASED_CAUSE_LOG_EN
  localparam bit LOG = 1'b1;
`else
  localparam bit LOG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [5:0]  va, vb;
  logic [15:0] pa, pb;
  logic        ra, ba, rb, bb;
  logic [5:0]  ca, cb;
  logic [7:0]  na, nb;

  always #5 clk = ~clk;

  vrased_reset_ctrl dut_a (
    .clk(clk), .reset_n(reset_n), .viol(va), .pc(pa),
    .sys_rst(ra), .busy(ba), .cause(ca), .viol_cnt(na)
  );

  vrased_reset_ctrl #(.HOLD_CYCLES(16'h0000)) dut_b (
    .clk(clk), .reset_n(reset_n), .viol(vb), .pc(pb),
    .sys_rst(rb), .busy(bb), .cause(cb), .viol_cnt(nb)
  );

  wire [15:0] obs_a = {ra, ba, ca, na};
  wire [15:0] obs_b = {rb, bb, cb, nb};

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          sel;
    logic [15:0] exp;
    string       tag;
  } sb_t;
  sb_t sbq[$];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] pack(input bit r, input bit b, input logic [5:0] c, input logic [7:0] n);
    return {r, b, (LOG ? c : 6'd0), (LOG ? n : 8'd0)};
  endfunction

  // Drive one cycle on the selected DUT, push expected post-edge outputs, then compare.
  task automatic cyc(input string tag, input bit sel, input logic [5:0] v, input logic [15:0] p,
                     input bit r, input bit b, input logic [5:0] c, input logic [7:0] n);
    sb_t e;
    if (sel) begin vb = v; pb = p; va = 6'd0; pa = 16'hFFFF; end
    else     begin va = v; pa = p; vb = 6'd0; pb = 16'hFFFF; end
    e.sel = sel; e.exp = pack(r, b, c, n); e.tag = tag;
    sbq.push_back(e);
    @(posedge clk); #1;
    e = sbq.pop_front();
    check(e.tag, e.sel ? obs_b : obs_a, e.exp);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    va = 6'd0; vb = 6'd0; pa = 16'hFFFF; pb = 16'hFFFF;
    #3;
    check("reset_a", obs_a, 16'h0000);
    check("reset_b", obs_b, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] v;
    logic [7:0] n;

    // Single-cycle AC violation: 16 reset cycles, then wait for the handler fetch.
    do_reset();
    cyc("s1_trig", 0, 6'h02, 16'hFFFF, 1, 1, 6'h02, 8'd1);
    repeat (15) cyc("s1_hold", 0, 6'h00, 16'hFFFF, 1, 1, 6'h02, 8'd1);
    repeat (3)  cyc("s1_wait", 0, 6'h00, 16'hFFFF, 0, 1, 6'h02, 8'd1);
    cyc("s1_pc",   0, 6'h00, 16'h0000, 0, 0, 6'h02, 8'd1);
    cyc("s1_idle", 0, 6'h00, 16'h0000, 0, 0, 6'h02, 8'd1);

    // Extra violation in the 5th hold cycle: ORs into cause, no reload/count.
    do_reset();
    cyc("s2_trig", 0, 6'h02, 16'hFFFF, 1, 1, 6'h02, 8'd1);
    repeat (3)  cyc("s2_hold", 0, 6'h00, 16'hFFFF, 1, 1, 6'h02, 8'd1);
    cyc("s2_inj", 0, 6'h10, 16'hFFFF, 1, 1, 6'h12, 8'd1);
    repeat (11) cyc("s2_hold2", 0, 6'h00, 16'hFFFF, 1, 1, 6'h12, 8'd1);
    cyc("s2_wait", 0, 6'h00, 16'hFFFF, 0, 1, 6'h12, 8'd1);

    // Violation together with handler PC in WAIT_PC: violation wins.
    cyc("s3_retrig", 0, 6'h01, 16'h0000, 1, 1, 6'h13, 8'd2);
    repeat (15) cyc("s3_hold", 0, 6'h00, 16'hFFFF, 1, 1, 6'h13, 8'd2);
    cyc("s3_wait", 0, 6'h00, 16'h0000, 0, 1, 6'h13, 8'd2);
    cyc("s3_done", 0, 6'h00, 16'h0000, 0, 0, 6'h13, 8'd2);

    // HOLD_CYCLES = 0 behaves as a single reset cycle.
    cyc("s4_trig", 1, 6'h04, 16'hFFFF, 1, 1, 6'h04, 8'd1);
    cyc("s4_wait", 1, 6'h00, 16'hFFFF, 0, 1, 6'h04, 8'd1);
    cyc("s4_done", 1, 6'h00, 16'h0000, 0, 0, 6'h04, 8'd1);

    // 300 complete episodes: counter saturates at FF.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      v = 6'(1 << (i % 6));
      n = (i < 255) ? 8'(i + 1) : 8'hFF;
      cyc("s5_trig", 0, v, 16'hFFFF, 1, 1, v, n);
      repeat (15) cyc("s5_hold", 0, 6'h00, 16'hFFFF, 1, 1, v, n);
      cyc("s5_wait", 0, 6'h00, 16'h0000, 0, 1, v, n);
      cyc("s5_done", 0, 6'h00, 16'h0000, 0, 0, v, n);
    end

    // One more episode, then async reset in the middle of HOLD.
    cyc("s5_sat", 0, 6'h20, 16'hFFFF, 1, 1, 6'h20, 8'hFF);
    repeat (4) cyc("s5_sat_hold", 0, 6'h00, 16'hFFFF, 1, 1, 6'h20, 8'hFF);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst", obs_a, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst", obs_a, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
